smac_seq_ctrl: RTL and testbench

SMAC_SEQ_CTRL -- requirements
Module: smac_seq_ctrl

---
 rtl/smac_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_smac_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/smac_seq_ctrl.sv
// Sequencer for a parallel SMAC datapath: accepts num_tiles tiles from a
// feeder, drives the SMAC register write enable, tracks which partial sums
// coming back out of the two-stage SMAC are real tiles, and accumulates
// them into a job result.
module smac_seq_ctrl #(
  parameter int M  = 64,
  parameter int Pa = 8,
  parameter int Pw = 4,
  parameter int KW = 8,
  localparam int PSW  = Pa + Pw + $clog2(M),
  localparam int ACCW = PSW + KW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   num_tiles,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            mac_w_en,
  input  logic [PSW-1:0]  par_sum,
  output logic            busy,
  output logic [ACCW-1:0] result,
  output logic            result_valid
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_ACCUM = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [KW-1:0] CNT_ONE = {{(KW-1){1'b0}}, 1'b1};

  logic [2:0]      state_q, state_d;
  logic [KW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   num_q, num_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [ACCW-1:0] res_q, res_d;
  // v1: SMAC input register holds a real tile; pv: output register does.
  logic            v1_q, v1_d;
  logic            pv_q, pv_d;
  logic            transfer;
  logic [KW-1:0]   cnt_inc;

  assign transfer     = (state_q == S_RUN) & in_valid;
  assign cnt_inc      = cnt_q + CNT_ONE;
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign result       = res_q;

  // Next-state: FSM, tile-validity pipeline and accumulator.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    acc_d    = acc_q;
    res_d    = res_q;
    v1_d     = v1_q;
    pv_d     = 1'b0;
    in_ready = 1'b0;
    mac_w_en = 1'b0;

    case (state_q)
      S_RUN: begin
        in_ready = 1'b1;
        mac_w_en = transfer;
      end
      S_FLUSH: mac_w_en = 1'b1;
      default: ;
    endcase

    // Validity follows the data through the SMAC's two registers; a stalled
    // SMAC keeps its input tile but its output is consumed exactly once.
    if (mac_w_en) begin
      v1_d = transfer;
      pv_d = v1_q;
    end
    if (pv_q) acc_d = acc_q + {{KW{1'b0}}, par_sum};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = '0;
          if (num_tiles != '0) begin
            num_d   = num_tiles;
            cnt_d   = '0;
            v1_d    = 1'b0;
            pv_d    = 1'b0;
            state_d = S_RUN;
          end else begin
            res_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (transfer) begin
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_ACCUM;
      S_ACCUM: begin
        // Last partial sum lands this cycle; publish the final total.
        res_d   = acc_d;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      v1_q    <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      v1_q    <= v1_d;
      pv_q    <= pv_d;
    end
  end

endmodule

// File: tb/tb_smac_seq_ctrl.sv
// Randomized bench for smac_seq_ctrl with a behavioural two-register SMAC.
// Expected results come from summing the dot products of the tiles the
// feeder handed over, and expected timing from counting delivered tiles.
module tb_smac_seq_ctrl;
  localparam int M = 4, Pa = 8, Pw = 4, KW = 4;
  localparam int PSW  = Pa + Pw + $clog2(M);
  localparam int ACCW = PSW + KW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [KW-1:0]   num_tiles = '0;
  logic            in_valid = 1'b0;
  logic            in_ready, mac_w_en, busy, result_valid;
  logic [PSW-1:0]  par_sum;
  logic [ACCW-1:0] result;

  logic [M-1:0][Pa-1:0] act = '0;
  logic [M-1:0][Pw-1:0] wt  = '0;
  logic [M-1:0][Pa-1:0] sa  = '0;
  logic [M-1:0][Pw-1:0] sw  = '0;
  logic [PSW-1:0]       ps  = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  smac_seq_ctrl #(.M(M), .Pa(Pa), .Pw(Pw), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
    .in_valid(in_valid), .in_ready(in_ready), .mac_w_en(mac_w_en),
    .par_sum(par_sum), .busy(busy), .result(result),
    .result_valid(result_valid)
  );

  function automatic int dot(input logic [M-1:0][Pa-1:0] a,
                             input logic [M-1:0][Pw-1:0] w);
    int s = 0;
    for (int i = 0; i < M; i++) s += int'(a[i]) * int'(w[i]);
    return s;
  endfunction

  // Behavioural SMAC: input register then output register, both gated.
  always @(posedge clk) begin
    if (mac_w_en) begin
      sa <= act;
      sw <= wt;
      ps <= PSW'(dot(sa, sw));
    end
  end
  assign par_sum = ps;

  task automatic set_tile(input bit fixed, input logic [Pa-1:0] av,
                          input logic [Pw-1:0] wv);
    for (int i = 0; i < M; i++) begin
      act[i] = fixed ? av : Pa'($urandom);
      wt[i]  = fixed ? wv : Pw'($urandom);
    end
  endtask

  // Runs one job; checks handshake, busy and result per cycle.
  // abort_at > 0 asserts rst in that cycle and returns without finishing.
  task automatic do_job(input int k, input bit fixed, input logic [Pa-1:0] av,
                        input logic [Pw-1:0] wv, input logic [31:0] stall_mask,
                        input int stall_pct, input bit noise, input int abort_at,
                        output logic [ACCW-1:0] got_res, output int got_cyc);
    int d = 0, t = -1, rv_exp = -1, c;
    bit running, iv, finished = 0;
    bit exp_mwe;
    logic [ACCW-1:0] exp_sum = '0;
    got_res = '0;
    got_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; num_tiles = KW'(k); in_valid = 1'($urandom); set_tile(0, 0, 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || mac_w_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs k=%0d got busy=%b rdy=%b mwe=%b want 0 0 0",
               k, busy, in_ready, mac_w_en);
    end
    if (k == 0) begin t = 0; rv_exp = 1; end
    for (c = 1; c <= 120; c++) begin
      @(posedge clk); #1;
      start = noise; num_tiles = KW'($urandom_range(1, 15));
      if (c == abort_at) rst = 1'b1;
      running = (t < 0);
      if (running) iv = !stall_mask[c] && ($urandom_range(99) >= stall_pct);
      else         iv = 1'($urandom);
      in_valid = iv;
      set_tile(fixed, av, wv);
      if (running && iv) begin
        exp_sum += ACCW'(dot(act, wt));
        d++;
        if (d == k) begin t = c; rv_exp = c + 3; end
      end
      exp_mwe = running ? iv : (k > 0 && c == t + 1);
      @(negedge clk);
      checks++;
      if (in_ready !== running || mac_w_en !== exp_mwe || busy !== 1'b1) begin
        errors++;
        $display("FAIL handshake k=%0d cyc=%0d got rdy=%b mwe=%b busy=%b want %b %b 1",
                 k, c, in_ready, mac_w_en, busy, running, exp_mwe);
      end
      checks++;
      if (result_valid !== (c == rv_exp)) begin
        errors++;
        $display("FAIL result_valid_timing k=%0d cyc=%0d got %b want %b",
                 k, c, result_valid, (c == rv_exp));
      end
      if (result_valid === 1'b1 && got_cyc < 0) begin
        got_res = result;
        got_cyc = c;
        checks++;
        if (result !== exp_sum) begin
          errors++;
          $display("FAIL result_value k=%0d got %0d want %0d", k, result, exp_sum);
        end
      end
      if (c == abort_at) begin finished = 1; break; end
      if (c == rv_exp) begin finished = 1; break; end
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL job_timeout k=%0d no result_valid within budget", k);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; num_tiles = 4'd3; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, mac_w_en, busy, result_valid} !== 4'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b mwe=%b busy=%b rv=%b res=%0d want all 0",
               in_ready, mac_w_en, busy, result_valid, result);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [ACCW-1:0] r; int cyc;
    do_job(3, 1, 8'd2, 4'd3, 32'd0, 0, 0, 0, r, cyc);
    checks++;
    if (r !== 72 || cyc != 6) begin
      errors++;
      $display("FAIL basic_job got res=%0d cyc=%0d want 72 6", r, cyc);
    end
  endtask

  task automatic test_stall();
    logic [ACCW-1:0] r; int cyc;
    do_job(2, 1, 8'd7, 4'd5, 32'b11100, 0, 0, 0, r, cyc);
    checks++;
    if (r !== 280 || cyc != 8) begin
      errors++;
      $display("FAIL stall_job got res=%0d cyc=%0d want 280 8", r, cyc);
    end
  endtask

  task automatic test_zero();
    logic [ACCW-1:0] r; int cyc;
    do_job(0, 0, 0, 0, 32'd0, 0, 0, 0, r, cyc);
    checks++;
    if (r !== 0 || cyc != 1) begin
      errors++;
      $display("FAIL zero_job got res=%0d cyc=%0d want 0 1", r, cyc);
    end
  endtask

  task automatic test_reset_midjob();
    logic [ACCW-1:0] r; int cyc;
    do_job(4, 0, 0, 0, 32'b100, 0, 0, 2, r, cyc);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, mac_w_en, busy, result_valid} !== 4'b0 || result !== '0) begin
      errors++;
      $display("FAIL midjob_reset got rdy=%b mwe=%b busy=%b rv=%b res=%0d want all 0",
               in_ready, mac_w_en, busy, result_valid, result);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; in_valid = 1'($urandom);
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL aborted_job_quiet got rv=%b busy=%b want 0 0", result_valid, busy);
      end
    end
    do_job(1, 1, 8'd255, 4'd15, 32'd0, 0, 0, 0, r, cyc);
    checks++;
    if (r !== 15300 || cyc != 4) begin
      errors++;
      $display("FAIL post_reset_job got res=%0d cyc=%0d want 15300 4", r, cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [ACCW-1:0] r; int cyc;
    do_job(3, 0, 0, 0, 32'd0, 20, 1, 0, r, cyc);
    do_job(2, 1, 8'd10, 4'd2, 32'd0, 0, 1, 0, r, cyc);
    checks++;
    if (r !== 160 || cyc != 5) begin
      errors++;
      $display("FAIL back_to_back got res=%0d cyc=%0d want 160 5", r, cyc);
    end
  endtask

  task automatic test_max();
    logic [ACCW-1:0] r; int cyc;
    do_job(15, 1, 8'd255, 4'd15, 32'd0, 0, 0, 0, r, cyc);
    checks++;
    if (r !== 229500 || cyc != 18) begin
      errors++;
      $display("FAIL max_job got res=%0d cyc=%0d want 229500 18", r, cyc);
    end
  endtask

  task automatic test_random();
    logic [ACCW-1:0] r; int cyc;
    for (int j = 0; j < 8; j++)
      do_job($urandom_range(0, 15), 0, 0, 0, 32'd0, 30, 1'($urandom), 0, r, cyc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_reset_midjob();
    test_back_to_back();
    test_max();
    test_random();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
